// File: rtl/sparse_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sparse_multiplier_pipe
// Purpose  : N_UNIT-lane stallable multiplier pipeline with sparsity masking,
//            signed/unsigned mode, output saturation and an active-MAC counter.
// Revision : 1.0
// ============================================================================
module sparse_multiplier_pipe #(
    parameter int N_UNIT = 128,
    parameter int DW_IN  = 8,
    parameter int DW_OUT = 16,
    parameter int PIPE   = 2,
    parameter int CNT_W  = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_UNIT*DW_IN-1:0]        in_a,
    input  logic [N_UNIT*DW_IN-1:0]        in_b,
    input  logic [N_UNIT-1:0]              in_mask,
    input  logic                           in_signed,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_UNIT*DW_OUT-1:0]       out_prod,
    output logic [N_UNIT-1:0]              out_mask,
    output logic                           out_last,
    output logic [$clog2(N_UNIT+1)-1:0]    out_active,
    input  logic                           perf_clear,
    output logic [CNT_W-1:0]               perf_macs
);

    localparam int ACT_W = $clog2(N_UNIT+1);
    localparam int PW    = 2*DW_IN;

    logic                      vld    [PIPE];
    logic [N_UNIT*DW_OUT-1:0]  prod_q [PIPE];
    logic [N_UNIT-1:0]         mask_q [PIPE];
    logic                      last_q [PIPE];
    logic [ACT_W-1:0]          act_q  [PIPE];
    logic [PIPE-1:0]           adv;

    logic [N_UNIT*DW_OUT-1:0]  next_prod;
    logic [ACT_W-1:0]          next_act;

    // adv[k]: stage k may load this cycle (empty, or its content moves on).
    always_comb begin
        logic run;
        adv = '0;
        run = out_ready;
        for (int k = PIPE-1; k >= 0; k--) begin
            run    = run | ~vld[k];
            adv[k] = run;
        end
    end

    assign in_ready = adv[0];

    always_comb begin
        next_act = '0;
        for (int i = 0; i < N_UNIT; i++) begin
            next_act = next_act + ACT_W'(in_mask[i]);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_UNIT; gi++) begin : g_lane
            logic [DW_IN-1:0]  a;
            logic [DW_IN-1:0]  b;
            logic [PW-1:0]     ax;
            logic [PW-1:0]     bx;
            logic [PW-1:0]     full;
            logic [DW_OUT-1:0] res;

            assign a    = in_a[gi*DW_IN +: DW_IN];
            assign b    = in_b[gi*DW_IN +: DW_IN];
            // Extending both operands to PW bits makes the truncated product
            // exact for either signedness.
            assign ax   = in_signed ? {{DW_IN{a[DW_IN-1]}}, a} : {{DW_IN{1'b0}}, a};
            assign bx   = in_signed ? {{DW_IN{b[DW_IN-1]}}, b} : {{DW_IN{1'b0}}, b};
            assign full = ax * bx;

            if (DW_OUT >= PW) begin : g_ext
                assign res = in_signed ? DW_OUT'($signed(full)) : DW_OUT'(full);
            end else begin : g_sat
                logic [PW-DW_OUT:0]   hi_s;
                logic [PW-DW_OUT-1:0] hi_u;
                logic                 fit_s;
                logic                 fit_u;

                assign hi_s  = full[PW-1:DW_OUT-1];
                assign hi_u  = full[PW-1:DW_OUT];
                assign fit_s = (&hi_s) | ~(|hi_s);
                assign fit_u = ~(|hi_u);

                always_comb begin
                    res = full[DW_OUT-1:0];
                    if (in_signed) begin
                        if (!fit_s) begin
                            res = full[PW-1] ? {1'b1, {(DW_OUT-1){1'b0}}}
                                             : {1'b0, {(DW_OUT-1){1'b1}}};
                        end
                    end else if (!fit_u) begin
                        res = '1;
                    end
                end
            end

            assign next_prod[gi*DW_OUT +: DW_OUT] = res;
            // Pruned lanes keep stale register contents; the mask zeroes them here.
            assign out_prod[gi*DW_OUT +: DW_OUT] =
                prod_q[PIPE-1][gi*DW_OUT +: DW_OUT] & {DW_OUT{mask_q[PIPE-1][gi]}};
        end
    endgenerate

    genvar gk;
    generate
        for (gk = 0; gk < PIPE; gk++) begin : g_stage
            logic [N_UNIT*DW_OUT-1:0] src_prod;
            logic [N_UNIT-1:0]        src_mask;
            logic                     src_last;
            logic [ACT_W-1:0]         src_act;
            logic                     src_vld;

            if (gk == 0) begin : g_first
                assign src_prod = next_prod;
                assign src_mask = in_mask;
                assign src_last = in_last;
                assign src_act  = next_act;
                assign src_vld  = in_valid;
            end else begin : g_next
                assign src_prod = prod_q[gk-1];
                assign src_mask = mask_q[gk-1];
                assign src_last = last_q[gk-1];
                assign src_act  = act_q[gk-1];
                assign src_vld  = vld[gk-1];
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld[gk]    <= 1'b0;
                    prod_q[gk] <= '0;
                    mask_q[gk] <= '0;
                    last_q[gk] <= 1'b0;
                    act_q[gk]  <= '0;
                end else if (adv[gk]) begin
                    vld[gk] <= src_vld;
                    if (src_vld) begin
                        mask_q[gk] <= src_mask;
                        last_q[gk] <= src_last;
                        act_q[gk]  <= src_act;
                        for (int i = 0; i < N_UNIT; i++) begin
                            if (src_mask[i]) begin
                                prod_q[gk][i*DW_OUT +: DW_OUT] <= src_prod[i*DW_OUT +: DW_OUT];
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    assign out_valid  = vld[PIPE-1];
    assign out_mask   = mask_q[PIPE-1];
    assign out_last   = last_q[PIPE-1];
    assign out_active = act_q[PIPE-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_macs <= '0;
        end else if (perf_clear) begin
            perf_macs <= '0;
        end else if (out_valid && out_ready) begin
            perf_macs <= perf_macs + CNT_W'(out_active);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sparse_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sparse_multiplier_pipe
// Purpose  : directed vector bench for sparse_multiplier_pipe (PIPE 1/2/4, DW_OUT 16/8).
// Revision : 1.0
// ============================================================================
module tb_sparse_multiplier_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_signed, in_last, out_ready, perf_clear;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_mask;

    logic        rdy_m, vld_m, last_m;
    logic [63:0] prod_m;
    logic [3:0]  mask_m;
    logic [2:0]  act_m;
    logic [31:0] perf_m;

    logic        rdy_s, vld_s, last_s;
    logic [31:0] prod_s;
    logic [3:0]  mask_s;
    logic [2:0]  act_s;
    logic [31:0] perf_s;

    logic        rdy_1, vld_1, last_1;
    logic [63:0] prod_1;
    logic [3:0]  mask_1;
    logic [2:0]  act_1;
    logic [31:0] perf_1;

    logic        rdy_4, vld_4, last_4;
    logic [63:0] prod_4;
    logic [3:0]  mask_4;
    logic [2:0]  act_4;
    logic [31:0] perf_4;

    always #5 clk = ~clk;

    sparse_multiplier_pipe #(.N_UNIT(4), .DW_IN(8), .DW_OUT(16), .PIPE(2), .CNT_W(32)) dut_m (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_m),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_signed(in_signed), .in_last(in_last),
        .out_valid(vld_m), .out_ready(out_ready), .out_prod(prod_m), .out_mask(mask_m),
        .out_last(last_m), .out_active(act_m), .perf_clear(perf_clear), .perf_macs(perf_m));

    sparse_multiplier_pipe #(.N_UNIT(4), .DW_IN(8), .DW_OUT(8), .PIPE(2), .CNT_W(32)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_signed(in_signed), .in_last(in_last),
        .out_valid(vld_s), .out_ready(out_ready), .out_prod(prod_s), .out_mask(mask_s),
        .out_last(last_s), .out_active(act_s), .perf_clear(perf_clear), .perf_macs(perf_s));

    sparse_multiplier_pipe #(.N_UNIT(4), .DW_IN(8), .DW_OUT(16), .PIPE(1), .CNT_W(32)) dut_1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_1),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_signed(in_signed), .in_last(in_last),
        .out_valid(vld_1), .out_ready(out_ready), .out_prod(prod_1), .out_mask(mask_1),
        .out_last(last_1), .out_active(act_1), .perf_clear(perf_clear), .perf_macs(perf_1));

    sparse_multiplier_pipe #(.N_UNIT(4), .DW_IN(8), .DW_OUT(16), .PIPE(4), .CNT_W(32)) dut_4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_4),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_signed(in_signed), .in_last(in_last),
        .out_valid(vld_4), .out_ready(out_ready), .out_prod(prod_4), .out_mask(mask_4),
        .out_last(last_4), .out_active(act_4), .perf_clear(perf_clear), .perf_macs(perf_4));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  mask;
        logic        sgn;
        logic [63:0] e16;
        logic [31:0] e8;
        int          act;
    } vec_t;

    vec_t tv [7];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    initial begin
        int          perf_exp;
        int          lat_m, lat_s, lat_1, lat_4;
        logic [63:0] cp_m, cp_1, cp_4;
        logic [31:0] cp_s;
        logic [3:0]  cm_m;
        logic [2:0]  ca_m;
        logic        cl_m;
        int          nvalid, sent, recv, stall;
        logic        seen, saw_full;
        logic [7:0]  a8;
        logic [15:0] p16;

        // a, b, mask, signed, 16-bit products, 8-bit saturated products, popcount
        tv[0] = '{32'h02_10_03_FF, 32'h80_10_05_FF, 4'b1111, 1'b0,
                  64'h0100_0100_000F_FE01, 32'hFF_FF_0F_FF, 4};
        tv[1] = '{32'h64_00_FF_80, 32'h64_55_7F_80, 4'b1111, 1'b1,
                  64'h2710_0000_FF81_4000, 32'h7F_00_81_7F, 4};
        tv[2] = '{32'h11_11_11_11, 32'h11_11_11_11, 4'b0101, 1'b0,
                  64'h0000_0121_0000_0121, 32'h00_FF_00_FF, 2};
        tv[3] = '{32'hFF_03_64_9C, 32'hFF_05_64_64, 4'b1111, 1'b1,
                  64'h0001_000F_2710_D8F0, 32'h01_0F_7F_80, 4};
        tv[4] = '{32'h0F_FF_03_14, 32'h11_FF_05_14, 4'b1011, 1'b0,
                  64'h00FF_0000_000F_0190, 32'hFF_00_0F_FF, 3};
        tv[5] = '{32'h7F_55_80_F0, 32'h01_55_FF_08, 4'b1011, 1'b1,
                  64'h007F_0000_0080_FF80, 32'h7F_00_7F_80, 3};
        tv[6] = '{32'hFF_FF_FF_FF, 32'hFF_FF_FF_FF, 4'b0000, 1'b0,
                  64'h0, 32'h0, 0};

        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mask = '0;
        in_signed = 1'b0; in_last = 1'b0; out_ready = 1'b1; perf_clear = 1'b0;
        perf_exp = 0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", vld_m, 0);
        chk("rst_in_ready", rdy_m, 1);
        chk("rst_out_prod", prod_m, 0);
        chk("rst_out_mask", mask_m, 0);
        chk("rst_out_last", last_m, 0);
        chk("rst_out_active", act_m, 0);
        chk("rst_perf", perf_m, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            in_a = tv[v].a; in_b = tv[v].b; in_mask = tv[v].mask;
            in_signed = tv[v].sgn; in_last = v[0]; in_valid = 1'b1;
            lat_m = 0; lat_s = 0; lat_1 = 0; lat_4 = 0;
            cp_m = '0; cp_s = '0; cp_1 = '0; cp_4 = '0; cm_m = '0; ca_m = '0; cl_m = 1'b0;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            for (int c = 1; c <= 8; c++) begin
                if (vld_m && lat_m == 0) begin
                    lat_m = c; cp_m = prod_m; cm_m = mask_m; ca_m = act_m; cl_m = last_m;
                end
                if (vld_s && lat_s == 0) begin lat_s = c; cp_s = prod_s; end
                if (vld_1 && lat_1 == 0) begin lat_1 = c; cp_1 = prod_1; end
                if (vld_4 && lat_4 == 0) begin lat_4 = c; cp_4 = prod_4; end
                @(posedge clk);
                #1;
            end
            chk($sformatf("v%0d_latency_p2", v), lat_m, 2);
            chk($sformatf("v%0d_prod16", v), cp_m, tv[v].e16);
            chk($sformatf("v%0d_mask", v), cm_m, tv[v].mask);
            chk($sformatf("v%0d_active", v), ca_m, tv[v].act);
            chk($sformatf("v%0d_last", v), cl_m, v[0]);
            chk($sformatf("v%0d_latency_sat", v), lat_s, 2);
            chk($sformatf("v%0d_prod8_sat", v), cp_s, tv[v].e8);
            chk($sformatf("v%0d_latency_p1", v), lat_1, 1);
            chk($sformatf("v%0d_prod_p1", v), cp_1, tv[v].e16);
            chk($sformatf("v%0d_latency_p4", v), lat_4, 4);
            chk($sformatf("v%0d_prod_p4", v), cp_4, tv[v].e16);
            perf_exp += tv[v].act;
            chk($sformatf("v%0d_perf", v), perf_m, perf_exp);
        end

        // Two beats in flight, then asynchronous reset mid-stream.
        @(negedge clk);
        out_ready = 1'b0;
        in_a = 32'h01_02_03_04; in_b = 32'h05_06_07_08; in_mask = 4'hF;
        in_signed = 1'b0; in_last = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_a = 32'h09_0A_0B_0C;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_out_valid", vld_m, 1);
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", vld_m, 0);
        chk("midrst_perf", perf_m, 0);
        chk("midrst_in_ready", rdy_m, 1);
        chk("midrst_prod", prod_m, 0);
        chk("midrst_active", act_m, 0);
        chk("midrst_out_valid_p4", vld_4, 0);
        perf_exp = 0;
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (vld_m || vld_1 || vld_4 || vld_s) nvalid++;
        end
        chk("post_rst_no_output", nvalid, 0);

        // Six back-to-back beats with a 4-cycle downstream stall.
        sent = 0; recv = 0; stall = 0; seen = 1'b0; saw_full = 1'b0;
        for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
            @(negedge clk);
            if (vld_m) seen = 1'b1;
            out_ready = !(seen && stall < 4);
            if (!out_ready) stall++;
            a8 = 8'(sent + 1);
            in_valid = (sent < 6);
            in_a = {4{a8}}; in_b = {4{8'h02}}; in_mask = 4'hF;
            in_signed = 1'b0; in_last = (sent == 5);
            perf_clear = (vld_m && out_ready && recv == 5);
            #1;
            chk($sformatf("bp_in_ready_c%0d", cyc), rdy_m, out_ready || (sent - recv) < 2);
            if (!rdy_m) saw_full = 1'b1;
            if (vld_m && out_ready) begin
                p16 = 16'(2 * (recv + 1));
                chk($sformatf("bp_prod_b%0d", recv), prod_m, {4{p16}});
                chk($sformatf("bp_last_b%0d", recv), last_m, recv == 5);
                chk($sformatf("bp_active_b%0d", recv), act_m, 4);
                if (!perf_clear) perf_exp += 4;
                recv++;
            end
            if (perf_clear) perf_exp = 0;
            if (in_valid && rdy_m) sent++;
            @(posedge clk);
        end
        #1;
        perf_clear = 1'b0;
        in_valid = 1'b0;
        chk("bp_all_delivered", recv, 6);
        chk("bp_all_sent", sent, 6);
        chk("bp_backpressure_seen", saw_full, 1);
        chk("bp_perf_clear_wins", perf_m, perf_exp);
        chk("bp_perf_zero", perf_m, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
